// File: rtl/nabp_swappable_stream_pkg.sv
// nabp_swappable_stream_pkg: shared FSM encoding, derived lengths and address clamp
package nabp_swappable_stream_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_FILL_DRAIN, ST_SWAP_REQ, ST_SHIFT, ST_SHIFT_DRAIN, ST_NEXT_REQ
  } state_e;
  function automatic int fill_len(input int no_parts, input int part_size);
    return (no_parts - 1) * part_size + 1;
  endfunction
  // Returns {oob, address}; the address saturates to [0, 2^s_w-1].
  function automatic logic [32:0] clamp_addr(input longint i, input int s_w);
    longint mx;
    mx = (longint'(1) << s_w) - 1;
    return i < 0 ? {1'b1, 32'd0} : i > mx ? {1'b1, mx[31:0]} : {1'b0, i[31:0]};
  endfunction
endpackage

// File: rtl/nabp_swappable_stream_tap_line_buffer.sv
// nabp_tap_line_buffer: delay line exposing NO_TAPS taps spaced DISTANCE samples apart
// Ports: clk, rst_n (async low), clr_i (sync clear), en_i (shift), shift_in_i,
//        taps_o (tap k at [k*DATA_W +: DATA_W], tap 0 = newest sample)
module nabp_tap_line_buffer import nabp_swappable_stream_pkg::*; #(
  parameter int NO_TAPS  = 4,
  parameter int DISTANCE = 16,
  parameter int DATA_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [DATA_W-1:0]         shift_in_i,
  output logic [NO_TAPS*DATA_W-1:0] taps_o
);
  localparam int LEN = fill_len(NO_TAPS, DISTANCE);
  logic [DATA_W-1:0] sr_q [LEN];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < LEN; i++) sr_q[i] <= '0;
    else if (clr_i) for (int i = 0; i < LEN; i++) sr_q[i] <= '0;
    else if (en_i) begin
      sr_q[0] <= shift_in_i;
      for (int i = 1; i < LEN; i++) sr_q[i] <= sr_q[i-1];
    end
  for (genvar k = 0; k < NO_TAPS; k++) begin : g_tap
    assign taps_o[k*DATA_W +: DATA_W] = sr_q[k*DISTANCE];
  end
endmodule

// File: rtl/nabp_swappable_stream.sv
// nabp_swappable_stream: fills a PE tap line from filtered RAM, swaps, streams one segment
// Ports: clk, reset_n (async low); swap control sw_start/sw_accu_init/sw_accu_base,
//        sw_swap_ack/sw_next_itr_ack in, sw_busy/sw_swap/sw_next_itr/sw_pe_en out;
//        RAM fr_s_val/fr_s_en out, fr_val in (RD_LAT later); PE taps pe_taps out.
// Option: NABP_SWAPPABLE_OOB_ZERO_EN makes out-of-range samples shift in zero.
module nabp_swappable_stream import nabp_swappable_stream_pkg::*; #(
  parameter int DATA_W    = 12,
  parameter int NO_PARTS  = 4,
  parameter int PART_SIZE = 16,
  parameter int S_W       = 10,
  parameter int ACCU_W    = 18,
  parameter int FRAC_W    = 6,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sw_start,
  input  logic [ACCU_W-1:0]          sw_accu_init,
  input  logic [ACCU_W-1:0]          sw_accu_base,
  input  logic                       sw_swap_ack,
  input  logic                       sw_next_itr_ack,
  input  logic [DATA_W-1:0]          fr_val,
  output logic                       sw_busy,
  output logic                       sw_swap,
  output logic                       sw_next_itr,
  output logic                       sw_pe_en,
  output logic [S_W-1:0]             fr_s_val,
  output logic                       fr_s_en,
  output logic [DATA_W*NO_PARTS-1:0] pe_taps
);
  localparam int LF = fill_len(NO_PARTS, PART_SIZE);
  localparam int LS = PART_SIZE;
  localparam int CW = $clog2(LF + 1) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACCU_W-1:0] accu_q, accu_d, base_q, base_d;
  logic [2:0] pl_q [RD_LAT];
  logic pe_q, clr, en, oob;
  logic signed [ACCU_W-FRAC_W-1:0] ipart;
  logic [32:0] cl;
  logic [31-S_W:0] cl_unused;
  logic [DATA_W-1:0] shift_in;
  assign ipart = accu_q[ACCU_W-1:FRAC_W];
  assign cl = clamp_addr(longint'(ipart), S_W);
  assign cl_unused = cl[31:S_W];
  assign oob = cl[32];
  assign en = state_q == ST_FILL || state_q == ST_SHIFT;
  assign fr_s_en = en;
  assign fr_s_val = en ? cl[S_W-1:0] : '0;
  assign sw_busy = state_q != ST_IDLE;
  assign sw_swap = state_q == ST_SWAP_REQ;
  assign sw_next_itr = state_q == ST_NEXT_REQ;
  assign sw_pe_en = pe_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    accu_d = accu_q;
    base_d = base_q;
    clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sw_start) begin
          state_d = ST_FILL;
          accu_d = sw_accu_init;
          base_d = sw_accu_base;
          clr = 1'b1;
        end
      end
      ST_FILL: begin
        accu_d = accu_q + base_q;
        if (cnt_q == CW'(LF - 1)) begin
          state_d = ST_FILL_DRAIN;
          cnt_d = '0;
        end
      end
      ST_FILL_DRAIN: if (cnt_q == CW'(RD_LAT - 1)) begin
        state_d = ST_SWAP_REQ;
        cnt_d = '0;
      end
      ST_SWAP_REQ: begin
        cnt_d = '0;
        if (sw_swap_ack) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        accu_d = accu_q + base_q;
        if (cnt_q == CW'(LS - 1)) begin
          state_d = ST_SHIFT_DRAIN;
          cnt_d = '0;
        end
      end
      ST_SHIFT_DRAIN: if (cnt_q == CW'(RD_LAT - 1)) begin
        state_d = ST_NEXT_REQ;
        cnt_d = '0;
      end
      ST_NEXT_REQ: begin
        cnt_d = '0;
        if (sw_next_itr_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // pl_q carries {shift_phase, oob, valid} alongside the RAM read latency.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      accu_q <= '0;
      base_q <= '0;
      pe_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      accu_q <= accu_d;
      base_q <= base_d;
      pl_q[0] <= {state_q == ST_SHIFT, oob, en};
      for (int i = 1; i < RD_LAT; i++) pl_q[i] <= pl_q[i-1];
      pe_q <= pl_q[RD_LAT-1][0] & pl_q[RD_LAT-1][2];
    end
`ifdef NABP_SWAPPABLE_OOB_ZERO_EN
  assign shift_in = pl_q[RD_LAT-1][1] ? '0 : fr_val;
`else
  logic oob_unused;
  assign oob_unused = pl_q[RD_LAT-1][1];
  assign shift_in = fr_val;
`endif
  nabp_tap_line_buffer #(.NO_TAPS(NO_PARTS), .DISTANCE(PART_SIZE), .DATA_W(DATA_W)) u_lb (
    .clk(clk),
    .rst_n(reset_n),
    .clr_i(clr),
    .en_i(pl_q[RD_LAT-1][0]),
    .shift_in_i(shift_in),
    .taps_o(pe_taps)
  );
endmodule

// File: tb/tb_nabp_swappable_stream.sv
// tb_nabp_swappable_stream: table and random runs on RD_LAT=1 and RD_LAT=3 instances
module tb_nabp_swappable_stream;
  localparam int DW = 12, NP = 4, PS = 4, SW = 10, AW = 18, FW = 4, LF = 13, LS = 4;
`ifdef NABP_SWAPPABLE_OOB_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  typedef struct {
    int init;
    int base;
    int dly;
    logic [NP*DW-1:0] fill;
    logic [NP*DW-1:0] fin;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, sw_start;
  logic [AW-1:0] init_v, base_v;
  int ack_dly = 0;
  bit stray_swap = 1'b0, stray_next = 1'b0;
  int checks = 0, failures = 0;

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int RL = g == 0 ? 1 : 3;
    logic busy, swap, nxt, pe_en, s_en;
    logic swap_ack = 1'b0, next_ack = 1'b0;
    logic [SW-1:0] s_val;
    logic [DW-1:0] fr_val;
    logic [NP*DW-1:0] taps, taps_swap, taps_last;
    logic [DW-1:0] rq [RL] = '{default: '0};
    int swap_hi = 0, next_hi = 0, k = 0, runs = 0;
    int swap_rise = -1, swap_fall = -1, pe_cnt = 0, pe_first = -1, pe_last = -1, next_rise = -1;
    bit act = 1'b0;
    int addr_q[$];
    nabp_swappable_stream #(.DATA_W(DW), .NO_PARTS(NP), .PART_SIZE(PS), .S_W(SW), .ACCU_W(AW),
                            .FRAC_W(FW), .RD_LAT(RL)) dut (
      .clk(clk), .reset_n(reset_n), .sw_start(sw_start), .sw_accu_init(init_v),
      .sw_accu_base(base_v), .sw_swap_ack(swap_ack), .sw_next_itr_ack(next_ack),
      .fr_val(fr_val), .sw_busy(busy), .sw_swap(swap), .sw_next_itr(nxt), .sw_pe_en(pe_en),
      .fr_s_val(s_val), .fr_s_en(s_en), .pe_taps(taps));
    // RAM holding data = address, read latency RL
    assign fr_val = rq[RL-1];
    always @(posedge clk) begin
      rq[0] <= DW'(s_val);
      for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
    end
    always @(negedge clk) begin
      swap_hi = swap ? swap_hi + 1 : 0;
      next_hi = nxt ? next_hi + 1 : 0;
      swap_ack = (swap && swap_hi == ack_dly + 1) || stray_swap;
      next_ack = (nxt && next_hi == ack_dly + 1) || stray_next;
      if (busy && !act) begin
        act = 1'b1;
        k = 0;
        addr_q.delete();
        swap_rise = -1; swap_fall = -1; pe_cnt = 0; pe_first = -1; pe_last = -1; next_rise = -1;
      end
      if (act) begin
        if (s_en) addr_q.push_back(int'(s_val));
        if (swap && swap_rise < 0) begin swap_rise = k; taps_swap = taps; end
        if (!swap && swap_rise >= 0 && swap_fall < 0) swap_fall = k;
        if (pe_en) begin
          pe_cnt++;
          if (pe_first < 0) pe_first = k;
          pe_last = k;
          taps_last = taps;
        end
        if (nxt && next_rise < 0) next_rise = k;
        if (!busy) begin act = 1'b0; runs++; end
        k++;
      end
    end
  end

  function automatic int m_addr(input int init, input int base, input int n, output bit oob);
    logic signed [AW-1:0] a;
    longint i;
    a = AW'(init + n * base);
    i = longint'(a >>> FW);
    oob = i < 0 || i > 1023;
    return i < 0 ? 0 : i > 1023 ? 1023 : int'(i);
  endfunction

  function automatic int m_data(input int init, input int base, input int n);
    bit o;
    int a;
    a = m_addr(init, base, n, o);
    return (o && ZERO_EN) ? 0 : a;
  endfunction

  function automatic logic [NP*DW-1:0] m_taps(input int init, input int base, input int last);
    logic [NP*DW-1:0] t;
    for (int j = 0; j < NP; j++) t[j*DW +: DW] = DW'(m_data(init, base, last - j * PS));
    return t;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int rl, input int sr, input int sf,
                           input int pc, input int pf, input int pl, input int nr,
                           input logic [NP*DW-1:0] ts, input logic [NP*DW-1:0] tl,
                           input int aq[$], input int init, input int base, input int dly,
                           input bit use_tab, input logic [NP*DW-1:0] tf,
                           input logic [NP*DW-1:0] tfin);
    int nbad;
    bit o;
    chk({tag, " swap_rise"}, sr, LF + rl);
    chk({tag, " swap_fall"}, sf, LF + rl + dly + 1);
    chk({tag, " next_rise"}, nr, LF + rl + dly + 1 + LS + rl);
    chk({tag, " pe_cnt"}, pc, LS);
    chk({tag, " pe_span"}, pl - pf + 1, LS);
    chk({tag, " taps_fill"}, ts, use_tab ? tf : m_taps(init, base, LF - 1));
    chk({tag, " taps_final"}, tl, use_tab ? tfin : m_taps(init, base, LF + LS - 1));
    chk({tag, " addr_count"}, aq.size(), LF + LS);
    nbad = 0;
    for (int n = 0; n < aq.size() && n < LF + LS; n++)
      if (aq[n] != m_addr(init, base, n, o)) nbad++;
    chk({tag, " addr_mismatches"}, nbad, 0);
  endtask

  task automatic run(input string tag, input int init, input int base, input int dly,
                     input bit stray, input bit use_tab, input logic [NP*DW-1:0] tf,
                     input logic [NP*DW-1:0] tfin);
    int r0, r1, t;
    r0 = gd[0].runs;
    r1 = gd[1].runs;
    @(negedge clk);
    ack_dly = dly;
    init_v = AW'(init);
    base_v = AW'(base);
    sw_start = 1'b1;
    @(negedge clk);
    sw_start = 1'b0;
    init_v = '1;
    base_v = '1;
    if (stray) begin
      stray_swap = 1'b1;
      stray_next = 1'b1;
      @(negedge clk);
      sw_start = 1'b1;
      @(negedge clk);
      sw_start = 1'b0;
      stray_swap = 1'b0;
      stray_next = 1'b0;
    end
    t = 0;
    while ((gd[0].runs == r0 || gd[1].runs == r1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " run_done"}, t < 400, 1);
    check_dut({tag, " rl1"}, 1, gd[0].swap_rise, gd[0].swap_fall, gd[0].pe_cnt, gd[0].pe_first,
              gd[0].pe_last, gd[0].next_rise, gd[0].taps_swap, gd[0].taps_last, gd[0].addr_q,
              init, base, dly, use_tab, tf, tfin);
    check_dut({tag, " rl3"}, 3, gd[1].swap_rise, gd[1].swap_fall, gd[1].pe_cnt, gd[1].pe_first,
              gd[1].pe_last, gd[1].next_rise, gd[1].taps_swap, gd[1].taps_last, gd[1].addr_q,
              init, base, dly, use_tab, tf, tfin);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rl1 outputs"}, longint'({gd[0].busy, gd[0].swap, gd[0].nxt, gd[0].pe_en,
        gd[0].s_en, gd[0].s_val, gd[0].taps}), 0);
    chk({tag, " rl3 outputs"}, longint'({gd[1].busy, gd[1].swap, gd[1].nxt, gd[1].pe_en,
        gd[1].s_en, gd[1].s_val, gd[1].taps}), 0);
  endtask

  initial begin
    vec_t tab[3];
    int t;
    tab[0] = '{16, 16, 5, {12'd1, 12'd5, 12'd9, 12'd13}, {12'd5, 12'd9, 12'd13, 12'd17}};
    tab[1] = '{-32, 8, 0, {12'd0, 12'd0, 12'd2, 12'd4}, {12'd0, 12'd2, 12'd4, 12'd6}};
    if (ZERO_EN)
      tab[2] = '{1022 * 16, 16, 2, {12'd1022, 12'd0, 12'd0, 12'd0}, {12'd0, 12'd0, 12'd0, 12'd0}};
    else
      tab[2] = '{1022 * 16, 16, 2, {12'd1022, 12'd1023, 12'd1023, 12'd1023},
                 {12'd1023, 12'd1023, 12'd1023, 12'd1023}};
    reset_n = 1'b0;
    sw_start = 1'b0;
    init_v = '0;
    base_v = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      run($sformatf("tab%0d", i), tab[i].init, tab[i].base, tab[i].dly, i == 0, 1'b1,
          tab[i].fill, tab[i].fin);
    for (int i = 0; i < 6; i++)
      run($sformatf("rnd%0d", i), (int'($urandom_range(0, 1100)) - 40) * 16 + int'($urandom_range(0, 15)),
          int'($urandom_range(0, 64)) - 16, int'($urandom_range(0, 4)), i[0], 1'b0, '0, '0);
    // reset in the middle of the shift phase
    @(negedge clk);
    ack_dly = 0;
    init_v = AW'(16);
    base_v = AW'(16);
    sw_start = 1'b1;
    @(negedge clk);
    sw_start = 1'b0;
    t = 0;
    while (gd[0].addr_q.size() < LF + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reset reached_shift", t < 200, 1);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    sw_start = 1'b1;
    stray_swap = 1'b1;
    stray_next = 1'b1;
    repeat (2) @(negedge clk);
    sw_start = 1'b0;
    stray_swap = 1'b0;
    stray_next = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("post_reset");
    run("fresh", tab[0].init, tab[0].base, tab[0].dly, 1'b0, 1'b1, tab[0].fill, tab[0].fin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
